fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS32 pipeline. Holds the PC, drives the word
//  address into the combinational instruction memory, captures the returned
//  word into the IF/ID pipeline register and applies decode-stage stalls and
//  branch/jump redirects. Feeds the decode stage.
// PARAMETERS
//  DATA_WIDTH  32  instruction / PC width in bits
//  ADDR_WIDTH  6   instruction-memory word-address width (64 words)
//  RESET_PC    0   byte address loaded into the PC on reset
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous active-low reset
//  stall          in   1           hold PC and IF/ID (load-use hazard)
//  flush          in   1           redirect taken: load redirect_pc, squash IF/ID
//  redirect_pc    in   DATA_WIDTH  branch/jump target byte address
//  instr_addr     out  ADDR_WIDTH  word address to instruction memory
//  instr          in   DATA_WIDTH  instruction word from memory (same cycle)
//  pc             out  DATA_WIDTH  current fetch PC (byte address)
//  if_id_instr    out  DATA_WIDTH  registered instruction for decode
//  if_id_pc4      out  DATA_WIDTH  registered PC+4 of that instruction
//  if_id_valid    out  1           IF/ID holds a real instruction
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, if_id_instr=0 (NOP),
//    if_id_pc4=0, if_id_valid=0. Takes effect immediately, mid-cycle
//    included. First fetch on the first rising edge after release.
//  - instr_addr = pc[ADDR_WIDTH+1:2], combinational. Upper PC bits ignored,
//    so the memory index wraps modulo 2^ADDR_WIDTH words.
//  - PC is always word-aligned: pc[1:0] is held at 0. redirect_pc[1:0] is
//    discarded on load.
//  - Per rising edge, in priority order:
//    1 flush=1 (stall is ignored): pc<=redirect_pc&~3; if_id_instr<=0;
//      if_id_pc4<=0; if_id_valid<=0. The word fetched this cycle is dropped.
//    2 stall=1: pc, if_id_instr, if_id_pc4 and if_id_valid all hold.
//    3 otherwise: if_id_instr<=instr; if_id_pc4<=pc+4; if_id_valid<=1;
//      pc<=pc+4.
//  - pc+4 is computed modulo 2^DATA_WIDTH: 0xFFFFFFFC+4 gives 0.
//  - Latency: the word at PC p appears on if_id_instr one edge after p is
//    presented on pc, unless that edge is stalled or flushed.
//  - After a flush the first valid IF/ID entry is the word at redirect_pc,
//    one edge later (1-cycle bubble).
//  - No internal hazard logic. stall and flush come from the decode stage
//    and hazard unit, and are sampled only at clk edges.
// TESTING
//  1 Reset: memory[i]=0x1000_0000+i, rst_n=0 -> pc=0, instr_addr=0,
//    if_id_valid=0, if_id_instr=0. Release, 3 edges -> if_id_instr=
//    0x10000002, if_id_pc4=0xC, pc=0xC.
//  2 Stall: assert stall for 2 edges at pc=0x8 -> pc stays 0x8 and IF/ID is
//    unchanged. Deassert -> next edge if_id_instr=0x10000002, pc=0xC.
//  3 Flush wins: stall=1, flush=1, redirect_pc=0x13 -> pc=0x10,
//    if_id_valid=0. Next edge -> if_id_instr=0x10000004, if_id_pc4=0x14.
//  4 Wrap: flush to 0xFFFFFFFC -> instr_addr=63. Next edge -> pc=0,
//    instr_addr=0, if_id_pc4=0.
//  5 Reset mid-run: drop rst_n between edges at pc=0x20 -> outputs return
//    to reset values immediately without a clock edge. Resume from
//    RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS32 pipeline: PC register, instruction-memory
// word addressing and the IF/ID pipeline register with stall/flush control.
`timescale 1ns/1ps
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [DATA_WIDTH-1:0] if_id_pc4,
    output logic                  if_id_valid
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc4;
    } if_id_t;

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    if_id_t                if_id_q;
    if_id_t                if_id_d;

    // Sequential PC increment wraps naturally at 2^DATA_WIDTH.
    assign pc_plus4 = pc_q + PC_STEP;

    // Next-state selection: flush beats stall, stall freezes everything.
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        if (flush) begin
            pc_d    = redirect_pc & ALIGN_MASK;
            if_id_d = '0;
        end else if (!stall) begin
            pc_d          = pc_plus4;
            if_id_d.valid = 1'b1;
            if_id_d.instr = instr;
            if_id_d.pc4   = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC & ALIGN_MASK;
            if_id_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    // Memory index drops the byte offset and any PC bits above the array.
    assign instr_addr  = pc_q[ADDR_WIDTH+1:2];
    assign pc          = pc_q;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver advances a behavioural pipeline
// model and queues expected state; a monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [5:0]  instr_addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    logic [31:0] mem [64];
    logic        async_tgl = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] valid;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(6),
        .RESET_PC  (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .instr_addr (instr_addr),
        .instr      (instr),
        .pc         (pc),
        .if_id_instr(if_id_instr),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid)
    );

    assign instr = mem[instr_addr];

    always #5 clk = ~clk;

    function automatic exp_t snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.addr  = (m_pc / 4) % 64;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.valid = {31'd0, m_valid};
        return e;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock of stimulus; the model predicts the state after the coming edge.
    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] rp);
        int idx;
        @(negedge clk);
        rst_n       = r;
        stall       = s;
        flush       = f;
        redirect_pc = rp;
        if (!r) begin
            model_reset();
        end else if (f) begin
            m_pc    = rp - (rp % 4);
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
        end else if (!s) begin
            idx     = int'((m_pc / 4) % 64);
            m_instr = mem[idx];
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
        exp_q.push_back(snapshot());
    endtask

    // Drop reset between edges; the monitor checks before any further edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(snapshot());
        async_tgl = ~async_tgl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or async_tgl);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("instr_addr", {26'd0, instr_addr}, e.addr);
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc4", if_id_pc4, e.pc4);
                chk("if_id_valid", {31'd0, if_id_valid}, e.valid);
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        model_reset();

        // Reset state before any clock edge
        #1;
        exp_q.push_back(snapshot());
        async_tgl = ~async_tgl;

        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Release, fetch to pc=0x8, stall two edges, resume
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        // Flush overrides stall, unaligned target
        step(1'b1, 1'b1, 1'b1, 32'h13);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        // PC wrap at the top of the address space
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        // Mid-cycle reset at pc=0x20
        step(1'b1, 1'b0, 1'b1, 32'h20);
        async_reset();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
                step(1'b0, 1'b0, 1'b0, 32'h0);
            end else begin
                step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 6) == 0, rp);
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
